nano_ctrl: RTL and testbench

Control unit of the nanoprocessor: fetch/decode/execute state machine that sequences the 8-bit ALU, the 256x8 RAM and the architectural registers.
- Registers: PC, IR, AD, accumulator, carry, zero flag.
- Each instruction is two bytes: opcode byte (low nibble used), then address byte.
- Drives the ALU opcode and A/Cin operands, commits ALU results, and performs stores and conditional jumps.

---
 rtl/nano_if.sv | 21 ++
 rtl/nano_ctrl.sv | 88 ++++++++
 tb/tb_nano_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nano_if.sv
// nano_if: RAM and ALU bus between the nanoprocessor control unit and its datapath
interface nano_if;
  logic [7:0] ram_addr;
  logic [7:0] ram_rdata;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [3:0] alu_i;
  logic [7:0] alu_a;
  logic       alu_cin;
  logic [7:0] alu_s;
  logic       alu_cout;
  logic       alu_z;
  modport master (
    output ram_addr, ram_wdata, ram_we, alu_i, alu_a, alu_cin,
    input  ram_rdata, alu_s, alu_cout, alu_z
  );
  modport slave (
    input  ram_addr, ram_wdata, ram_we, alu_i, alu_a, alu_cin,
    output ram_rdata, alu_s, alu_cout, alu_z
  );
endinterface

// File: rtl/nano_ctrl.sv
// nano_ctrl: fetch/decode/execute control unit of the nanoprocessor; NANO_STEP_EN adds single-step gating
module nano_ctrl #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [7:0] ACC_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
`ifdef NANO_STEP_EN
  input  logic       step,
`endif
  nano_if.master     bus,
  output logic [7:0] acc,
  output logic [7:0] pc,
  output logic       carry,
  output logic       zero,
  output logic       halted
);
  typedef enum logic [2:0] {FETCH_OP, DECODE_OP, FETCH_AD, EXEC, HALT} state_t;
  state_t     state, nxt;
  logic [3:0] ir;
  logic [7:0] ad;
  logic       go;
`ifdef NANO_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif
  assign bus.ram_wdata = acc;
  assign bus.alu_i     = ir;
  assign bus.alu_a     = acc;
  assign bus.alu_cin   = carry;
  assign halted        = (state == HALT);
  // next state and RAM address/write strobe decoded from the current state
  always_comb begin
    nxt = state;
    bus.ram_addr = pc;
    bus.ram_we = 1'b0;
    case (state)
      FETCH_OP:  nxt = go ? DECODE_OP : FETCH_OP;
      DECODE_OP: begin
        bus.ram_addr = pc + 8'd1;
        nxt = FETCH_AD;
      end
      FETCH_AD:  begin
        bus.ram_addr = bus.ram_rdata;
        nxt = EXEC;
      end
      EXEC:      begin
        bus.ram_addr = ad;
        bus.ram_we = (ir == 4'd10);
        nxt = (ir == 4'd15) ? HALT : FETCH_OP;
      end
      default:   nxt = HALT;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH_OP;
    else state <= nxt;
  // architectural registers: opcode/address capture, ALU commit and jumps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      acc   <= ACC_RESET;
      carry <= 1'b0;
      zero  <= 1'b0;
      ir    <= 4'd0;
      ad    <= 8'd0;
    end else begin
      case (state)
        DECODE_OP: begin
          ir <= bus.ram_rdata[3:0];
          pc <= pc + 8'd2;
        end
        FETCH_AD:  ad <= bus.ram_rdata;
        EXEC:      begin
          if (ir <= 4'd9) begin
            acc  <= bus.alu_s;
            zero <= bus.alu_z;
          end
          if (ir >= 4'd4 && ir <= 4'd9) carry <= bus.alu_cout;
          if (ir == 4'd11 || (ir == 4'd12 && !carry) || (ir == 4'd13 && !zero)) pc <= ad;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nano_ctrl.sv
// tb_nano_ctrl: directed and random programs checked against an instruction-level reference model
module tb_nano_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef NANO_STEP_EN
  logic step = 1'b1;
`endif
  logic [7:0] acc, pc;
  logic carry, zero, halted;
  nano_if bus();
  nano_ctrl #(.RESET_PC(8'h00), .ACC_RESET(8'h00)) dut (
    .clk(clk),
    .reset(reset),
`ifdef NANO_STEP_EN
    .step(step),
`endif
    .bus(bus),
    .acc(acc),
    .pc(pc),
    .carry(carry),
    .zero(zero),
    .halted(halted)
  );
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic       ld_we = 1'b0;
  logic [7:0] ld_a = 8'd0, ld_d = 8'd0;
  int         we_cnt = 0;
  int         vectors = 0, miscompares = 0;

  // synchronous-read RAM with a bench load port used while the DUT is in reset
  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      we_cnt <= we_cnt + 1;
    end else if (ld_we) mem[ld_a] <= ld_d;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, b, input logic cin);
    case (op)
      4'd0: return {1'b0, b};
      4'd1: return {1'b0, a & b};
      4'd2: return {1'b0, a | b};
      4'd3: return {1'b0, a ^ b};
      4'd4: return {1'b0, a} + {1'b0, b};
      4'd5: return {1'b0, a} + {1'b0, b} + {8'd0, cin};
      4'd6: return {1'b0, a} - {1'b0, b};
      4'd7: return {1'b0, a} - {1'b0, b} - {8'd0, cin};
      4'd8: return {a, 1'b0};
      4'd9: return {a[0], cin, a[7:1]};
      default: return 9'd0;
    endcase
  endfunction

  // behavioural ALU attached to the bus
  always_comb {bus.alu_cout, bus.alu_s} = alu_f(bus.alu_i, bus.alu_a, bus.ram_rdata, bus.alu_cin);
  assign bus.alu_z = (bus.alu_s == 8'd0);

  logic [7:0] rm [256];
  logic [7:0] r_pc, r_acc;
  logic r_c, r_z, r_h;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_a = a;
    ld_d = d;
    ld_we = 1'b1;
    tick;
    ld_we = 1'b0;
    rm[a] = d;
  endtask

  task automatic model_reset;
    r_pc = 8'h00;
    r_acc = 8'h00;
    r_c = 1'b0;
    r_z = 1'b0;
    r_h = 1'b0;
  endtask

  task automatic ref_step;
    logic [3:0] op;
    logic [7:0] ad, nx;
    logic [8:0] res;
    if (r_h) return;
    op = rm[r_pc][3:0];
    ad = rm[r_pc + 8'd1];
    nx = r_pc + 8'd2;
    if (op <= 4'd9) begin
      res = alu_f(op, r_acc, rm[ad], r_c);
      r_acc = res[7:0];
      r_z = (res[7:0] == 8'd0);
      if (op >= 4'd4) r_c = res[8];
    end
    if (op == 4'd10) rm[ad] = r_acc;
    if (op == 4'd11 || (op == 4'd12 && !r_c) || (op == 4'd13 && !r_z)) nx = ad;
    if (op == 4'd15) r_h = 1'b1;
    r_pc = nx;
  endtask

  task automatic cmp_state(input string tag);
    chk({tag, ".pc"}, pc, r_pc);
    chk({tag, ".acc"}, acc, r_acc);
    chk({tag, ".carry"}, carry, r_c);
    chk({tag, ".zero"}, zero, r_z);
    chk({tag, ".halted"}, halted, r_h);
  endtask

  task automatic instr(input string tag);
    int w0;
    logic sta;
    w0 = we_cnt;
    sta = !r_h && rm[r_pc][3:0] == 4'd10;
    repeat (4) tick;
    ref_step;
    cmp_state(tag);
    chk({tag, ".we_cycles"}, we_cnt - w0, sta ? 1 : 0);
  endtask

  initial begin
    tick;
    tick;
    chk("rst.pc", pc, 8'h00);
    chk("rst.acc", acc, 8'h00);
    chk("rst.carry", carry, 1'b0);
    chk("rst.zero", zero, 1'b0);
    chk("rst.halted", halted, 1'b0);
    chk("rst.we", bus.ram_we, 1'b0);
    // directed program
    for (int i = 0; i < 256; i++) poke(i[7:0], 8'h00);
    poke(8'h01, 8'h10); poke(8'h10, 8'h5A);
    poke(8'h03, 8'h20); poke(8'h20, 8'hF0);
    poke(8'h04, 8'h04); poke(8'h05, 8'h21); poke(8'h21, 8'h20);
    poke(8'h06, 8'h05); poke(8'h07, 8'h22);
    poke(8'h09, 8'h23); poke(8'h23, 8'h33);
    poke(8'h0A, 8'h0A); poke(8'h0B, 8'h80);
    poke(8'h0C, 8'h0D); poke(8'h0D, 8'h40);
    poke(8'h41, 8'h22);
    poke(8'h42, 8'h0D); poke(8'h43, 8'h60);
    poke(8'h45, 8'h20);
    poke(8'h46, 8'h04); poke(8'h47, 8'h21);
    poke(8'h48, 8'h0C); poke(8'h49, 8'h60);
    poke(8'h4A, 8'h0B); poke(8'h4B, 8'hFE);
    poke(8'hFE, 8'h0F);
    model_reset;
    reset = 1'b0;
    instr("lda5a");
    chk("lda5a.acc_k", acc, 8'h5A);
    chk("lda5a.pc_k", pc, 8'h02);
    instr("ldaf0");
    instr("add");
    chk("add.acc_k", acc, 8'h10);
    chk("add.carry_k", carry, 1'b1);
    instr("adc");
    chk("adc.acc_k", acc, 8'h11);
    chk("adc.carry_k", carry, 1'b0);
    instr("lda33");
    begin
      int w0;
      w0 = we_cnt;
      repeat (3) tick;
      chk("sta.we", bus.ram_we, 1'b1);
      chk("sta.addr", bus.ram_addr, 8'h80);
      chk("sta.wdata", bus.ram_wdata, 8'h33);
      tick;
      ref_step;
      chk("sta.we_cycles", we_cnt - w0, 1);
      chk("sta.mem", mem[8'h80], 8'h33);
      cmp_state("sta");
    end
    instr("jnz_taken");
    chk("jnz_taken.pc_k", pc, 8'h40);
    instr("lda00");
    instr("jnz_not");
    chk("jnz_not.pc_k", pc, 8'h44);
    instr("ldaf0b");
    instr("add2");
    instr("jnc_not");
    chk("jnc_not.pc_k", pc, 8'h4A);
    instr("jmp");
    chk("jmp.pc_k", pc, 8'hFE);
    instr("hlt");
    chk("hlt.pc_k", pc, 8'h00);
    chk("hlt.halted_k", halted, 1'b1);
    repeat (20) tick;
    chk("hold.pc", pc, 8'h00);
    chk("hold.halted", halted, 1'b1);
    chk("hold.we", bus.ram_we, 1'b0);
    // reset in the middle of a store
    reset = 1'b1;
    tick;
    poke(8'h00, 8'h0A); poke(8'h01, 8'h80); poke(8'h80, 8'h77);
    reset = 1'b0;
    repeat (3) tick;
    chk("rsta.we_exec", bus.ram_we, 1'b1);
    reset = 1'b1;
    #1;
    chk("rsta.we_drop", bus.ram_we, 1'b0);
    chk("rsta.pc", pc, 8'h00);
    chk("rsta.halted", halted, 1'b0);
    tick;
    chk("rsta.mem", mem[8'h80], 8'h77);
`ifdef NANO_STEP_EN
    step = 1'b0;
    reset = 1'b0;
    repeat (10) tick;
    chk("step.frozen", pc, 8'h00);
    step = 1'b1;
    tick;
    step = 1'b0;
    repeat (13) tick;
    chk("step.one_pc", pc, 8'h02);
    chk("step.one_mem", mem[8'h80], 8'h00);
    step = 1'b1;
    reset = 1'b1;
    tick;
`endif
    // random programs
    for (int p = 0; p < 6; p++) begin
      int bad;
      reset = 1'b1;
      tick;
      for (int i = 0; i < 256; i++) poke(i[7:0], 8'($urandom));
      model_reset;
      reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
        instr($sformatf("rnd%0d_%0d", p, k));
        if (r_h) break;
      end
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== rm[i]) bad++;
      chk($sformatf("rnd%0d.mem", p), bad, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
